// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM encoding, default width and overflow helper for serial_subtractor.
package serial_sub_pkg;

    // IDLE: waiting for start; RUN: one bit per clock; DONE: results valid for one cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 8;

    // Two's complement overflow of a - b: operand signs differ and the result
    // sign does not follow the minuend.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/fullsub_cell.sv
// fullsub_cell: combinational 1-bit full subtractor.
//   a, b, bin : minuend bit, subtrahend bit, borrow-in
//   d, bout   : difference bit, borrow-out
module fullsub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit DataA - DataB - Bin, LSB first, one bit per clock.
//   clk, rst        : clock, synchronous active-high reset
//   start           : request, accepted in IDLE or DONE
//   DataA/DataB/Bin : operands, captured on accept
//   busy            : high during the WIDTH processing cycles
//   done            : one-cycle pulse when Diff/Bout/Ovf are valid
//   Diff/Bout/Ovf   : difference, unsigned borrow-out, signed overflow (held until next accept)
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               brw_q, brw_d, am_q, am_d, bm_q, bm_d;
    logic               bit_d, bit_bout;

    fullsub_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (brw_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        am_d    = am_q;
        bm_d    = bm_q;
        if (start && state_q != RUN) begin
            a_d     = DataA;
            b_d     = DataB;
            brw_d   = Bin;
            cnt_d   = '0;
            am_d    = DataA[WIDTH-1];
            bm_d    = DataB[WIDTH-1];
            state_d = RUN;
        end else if (state_q == RUN) begin
            // difference bits enter at the MSB so the word is aligned after WIDTH shifts
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            diff_d  = {bit_d, diff_q[WIDTH-1:1]};
            brw_d   = bit_bout;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_q == LAST) ? DONE : RUN;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            am_q    <= 1'b0;
            bm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            am_q    <= am_d;
            bm_q    <= bm_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign Diff = diff_q;
    assign Bout = brw_q;
    assign Ovf  = sub_ovf(am_q, bm_q, diff_q[WIDTH-1]);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized self-checking bench for serial_subtractor against an arithmetic model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, Bin, busy, done, Bout, Ovf;
    logic [W-1:0] DataA, DataB, Diff;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .DataA (DataA),
        .DataB (DataB),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .Bout  (Bout),
        .Ovf   (Ovf)
    );

    // {borrow, difference} of the unsigned subtraction, modulo 2^(W+1)
    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    endfunction

    // signed result outside the W-bit two's complement range
    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        int sa, sb, s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        s  = sa - sb - int'(bi);
        return (s < -(2 ** (W - 1))) || (s > 2 ** (W - 1) - 1);
    endfunction

    // Called #1 after a rising edge; launches one operation and returns when done is seen.
    // With noise set, start and operands are toggled randomly while the DUT is running.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input bit noise,
                         output int lat, output int busy_cnt, output logic [W-1:0] d,
                         output logic bo, output logic ov, output bit to);
        DataA = a;
        DataB = b;
        Bin   = bi;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 4 * W) begin
            if (busy) busy_cnt++;
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            DataA = W'($urandom);
            DataB = W'($urandom);
            Bin   = 1'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        d     = Diff;
        bo    = Bout;
        ov    = Ovf;
        to    = !done;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        DataA = '0;
        DataB = '0;
        Bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, Diff, Bout, Ovf} !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b Diff=%h Bout=%b Ovf=%b, expected all 0", busy, done, Diff, Bout, Ovf);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [5] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F};
        logic [W-1:0] vb [5] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF};
        logic         vi [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] ed [5] = '{8'h02, 8'hFE, 8'hFF, 8'h7F, 8'h80};
        logic         eb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic         eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat, bc;
        logic [W-1:0] d;
        logic bo, ov;
        bit to;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vi[i], 1'b0, lat, bc, d, bo, ov, to);
            checks++;
            if (to || lat != W || bc != W) begin
                errors++;
                $display("FAIL directed%0d timing: latency=%0d busy_cycles=%0d timeout=%0b, expected %0d/%0d/0", i, lat, bc, to, W, W);
            end
            checks++;
            if ({d, bo, ov} !== {ed[i], eb[i], eo[i]}) begin
                errors++;
                $display("FAIL directed%0d result: Diff=%h Bout=%b Ovf=%b, expected Diff=%h Bout=%b Ovf=%b", i, d, bo, ov, ed[i], eb[i], eo[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_ignore_start();
        int lat, bc;
        logic [W-1:0] d;
        logic bo, ov;
        bit to;
        do_op(8'h80, 8'h01, 1'b0, 1'b1, lat, bc, d, bo, ov, to);
        checks++;
        if (to || lat != W || {d, bo, ov} !== {8'h7F, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ignore_start: latency=%0d Diff=%h Bout=%b Ovf=%b, expected latency=%0d Diff=7f Bout=0 Ovf=1", lat, d, bo, ov, W);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [W-1:0] d;
        logic bo, ov;
        bit to;
        do_op(8'h05, 8'h03, 1'b0, 1'b0, lat, bc, d, bo, ov, to);
        // now in the DONE cycle: start is accepted at the very next edge
        do_op(8'h03, 8'h05, 1'b0, 1'b0, lat, bc, d, bo, ov, to);
        checks++;
        if (to || lat != W || bc != W || {d, bo, ov} !== {8'hFE, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL back_to_back: latency=%0d busy_cycles=%0d Diff=%h Bout=%b Ovf=%b, expected %0d/%0d fe/1/0", lat, bc, d, bo, ov, W, W);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset();
        int lat, bc, seen;
        logic [W-1:0] d;
        logic bo, ov;
        bit to;
        DataA = 8'h80;
        DataB = 8'h01;
        Bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, Diff, Bout, Ovf} !== '0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b Diff=%h Bout=%b Ovf=%b, expected all 0", busy, done, Diff, Bout, Ovf);
        end
        seen = 0;
        for (int i = 0; i < W + 3; i++) begin
            if (done || busy) seen++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_quiet: busy/done cycles after reset=%0d, expected 0", seen);
        end
        do_op(8'h10, 8'h01, 1'b0, 1'b0, lat, bc, d, bo, ov, to);
        checks++;
        if (to || lat != W || {d, bo, ov} !== {8'h0F, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_restart: latency=%0d Diff=%h Bout=%b Ovf=%b, expected %0d 0f/0/0", lat, d, bo, ov, W);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int lat, bc, gap;
        logic [W-1:0] a, b, d;
        logic bi, bo, ov, eov;
        logic [W:0] exp;
        bit to;
        for (int n = 0; n < 3000; n++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            bi  = 1'($urandom);
            exp = ref_sub(a, b, bi);
            eov = ref_ovf(a, b, bi);
            do_op(a, b, bi, ($urandom_range(0, 3) == 0), lat, bc, d, bo, ov, to);
            checks++;
            if (to || lat != W || bc != W || {bo, d, ov} !== {exp, eov}) begin
                errors++;
                $display("FAIL random op %0d (%h-%h-%b): latency=%0d Bout=%b Diff=%h Ovf=%b, expected latency=%0d Bout=%b Diff=%h Ovf=%b",
                         n, a, b, bi, lat, bo, d, ov, W, exp[W], exp[W-1:0], eov);
            end
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
                checks++;
                if (busy || done || {Bout, Diff, Ovf} !== {exp, eov}) begin
                    errors++;
                    $display("FAIL random hold %0d: busy=%b done=%b Bout=%b Diff=%h Ovf=%b, expected idle holding %b/%h/%b",
                             n, busy, done, Bout, Diff, Ovf, exp[W], exp[W-1:0], eov);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
